// File: rtl/avm_burst_responder_pkg.sv
// Shared types and constants for the Avalon-MM burst responder.
package avm_burst_responder_pkg;

  // Width of the Avalon burstcount field and of every beat counter.
  localparam int unsigned BURSTCOUNT_W = 8;

  // Random-wait LFSR: 16-bit Fibonacci, taps 16,14,13,11 (bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST
  } state_e;

  // Shift left, feeding the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avm_burst_responder_if.sv
// Avalon-MM bus between a traffic generator (master) and the responder (slave).
// Signal suffixes are from the slave's point of view.
interface avm_burst_responder_if #(
  parameter int DATA_SIZE = 16
);
  logic                   avm_write_i;
  logic                   avm_read_i;
  logic [31:0]            avm_address_i;
  logic [DATA_SIZE-1:0]   avm_writedata_i;
  logic [DATA_SIZE/8-1:0] avm_byteenable_i;
  logic [7:0]             avm_burstcount_i;
  logic [DATA_SIZE-1:0]   avm_readdata_o;
  logic                   avm_readdatavalid_o;
  logic                   avm_waitrequest_o;

  modport master (
    output avm_write_i, avm_read_i, avm_address_i, avm_writedata_i,
           avm_byteenable_i, avm_burstcount_i,
    input  avm_readdata_o, avm_readdatavalid_o, avm_waitrequest_o
  );

  modport slave (
    input  avm_write_i, avm_read_i, avm_address_i, avm_writedata_i,
           avm_byteenable_i, avm_burstcount_i,
    output avm_readdata_o, avm_readdatavalid_o, avm_waitrequest_o
  );
endinterface

// File: rtl/avm_burst_responder_ram.sv
// Single-port synchronous RAM with per-byte write enables and a 1-cycle read.
module avm_burst_responder_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  // Byte-masked write and registered read of the addressed word.
  // NOTE: the array has no reset branch so it maps onto block RAM; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/avm_burst_responder.sv
// Avalon-MM burst responder backed by a byte-enable RAM, standing in for the
// HyperRAM controller. A read accepted in cycle T returns its first beat at
// T+G_READ_LATENCY: the RAM supplies one cycle, a valid/data delay line the rest.
// Optional build macro RESPONDER_RANDOM_WAIT_EN adds LFSR-driven waitrequest
// stalls in IDLE and WR_BURST.
module avm_burst_responder
  import avm_burst_responder_pkg::*;
#(
  parameter int G_ADDRESS_SIZE = 10,
  parameter int G_DATA_SIZE    = 16,
  parameter int G_READ_LATENCY = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  avm_burst_responder_if.slave avm,
  output logic                 err_o
);

  localparam int AW = G_ADDRESS_SIZE;
  localparam int DL = G_READ_LATENCY - 1;  // delay stages after the RAM

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;      // next word to write or to read
  logic [BURSTCOUNT_W-1:0] rem_q, rem_d;        // beats left to write / to issue
  logic [BURSTCOUNT_W-1:0] len_q, len_d;        // read burst length
  logic [BURSTCOUNT_W-1:0] beat_q, beat_d;      // read beats delivered so far
  logic                    err_q, err_d;
  logic                    rd_v_q;              // RAM output holds an issued read

  logic                    wait_req;
  logic                    wait_rand;
  logic                    ram_we;
  logic                    rd_issue;
  logic [AW-1:0]           ram_addr;
  logic [G_DATA_SIZE-1:0]  ram_rdata;
  logic [BURSTCOUNT_W-1:0] len_in;
  logic [AW-1:0]           addr_in;

  logic [G_DATA_SIZE-1:0]  dl_data_q [DL];
  logic [DL-1:0]           dl_valid_q;

  logic                    unused_addr_bits;
  assign unused_addr_bits = ^avm.avm_address_i[31:AW];

`ifdef RESPONDER_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;

  // Free-running stall generator, restarted from a fixed seed by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign wait_rand = (lfsr_q[1:0] == 2'b00);
`else
  assign wait_rand = 1'b0;
`endif

  // A read burst holds the bus until its last beat; otherwise only random stalls.
  assign wait_req = (state_q == RD_BURST) || wait_rand;

  // A burstcount of 0 is treated as a single beat.
  assign len_in  = (avm.avm_burstcount_i == '0) ? BURSTCOUNT_W'(1) : avm.avm_burstcount_i;
  assign addr_in = avm.avm_address_i[AW-1:0];

  // Next-state, RAM control and error logic.
  // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    len_d    = len_q;
    beat_d   = beat_q;
    err_d    = err_q;
    ram_we   = 1'b0;
    rd_issue = 1'b0;
    ram_addr = addr_q;

    case (state_q)
      IDLE: begin
        ram_addr = addr_in;
        if (avm.avm_write_i && !wait_req) begin
          ram_we = 1'b1;
          addr_d = addr_in + 1'b1;
          if (avm.avm_read_i) err_d = 1'b1;  // write wins, read dropped
          if (len_in != BURSTCOUNT_W'(1)) begin
            rem_d   = len_in - 1'b1;
            state_d = WR_BURST;
          end
        end else if (avm.avm_read_i && !wait_req) begin
          rd_issue = 1'b1;                   // beat 0 read straight from the bus address
          addr_d   = addr_in + 1'b1;
          rem_d    = len_in - 1'b1;
          len_d    = len_in;
          beat_d   = '0;
          state_d  = RD_BURST;
        end
      end

      WR_BURST: begin
        if (avm.avm_read_i) err_d = 1'b1;
        if (avm.avm_write_i && !wait_req) begin
          ram_we = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == BURSTCOUNT_W'(1)) state_d = IDLE;
        end
      end

      RD_BURST: begin
        if (rem_q != '0) begin
          rd_issue = 1'b1;
          addr_d   = addr_q + 1'b1;
          rem_d    = rem_q - 1'b1;
        end
        if (avm.avm_readdatavalid_o) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == len_q - 1'b1) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      rd_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      rd_v_q  <= rd_issue;
    end
  end

  avm_burst_responder_ram #(
    .ADDR_W (AW),
    .DATA_W (G_DATA_SIZE)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .be_i    (avm.avm_byteenable_i),
    .addr_i  (ram_addr),
    .wdata_i (avm.avm_writedata_i),
    .rdata_o (ram_rdata)
  );

  // Delay line padding the RAM read out to the configured latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dl_valid_q <= '0;
      for (int i = 0; i < DL; i++) dl_data_q[i] <= '0;
    end else begin
      dl_valid_q[0] <= rd_v_q;
      dl_data_q[0]  <= ram_rdata;
      for (int i = 1; i < DL; i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_data_q[i]  <= dl_data_q[i-1];
      end
    end
  end

  assign avm.avm_readdata_o      = dl_data_q[DL-1];
  assign avm.avm_readdatavalid_o = dl_valid_q[DL-1];
  assign avm.avm_waitrequest_o   = wait_req;
  assign err_o                   = err_q;

endmodule

// File: tb/tb_avm_burst_responder.sv
// Directed bench for avm_burst_responder. Read expectations (data and the
// cycle they must appear in) go into a scoreboard queue when the read is
// accepted; an independent monitor checks every readdatavalid beat.
module tb_avm_burst_responder;

  localparam int L = 4;

  typedef struct {
    logic [15:0] d;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   idle_wait_cnt = 0;
  exp_t sb[$];
  logic [15:0] exp_vec [8];
  logic [15:0] wvec [8];

  avm_burst_responder_if #(.DATA_SIZE(16)) bus ();

  avm_burst_responder #(
    .G_ADDRESS_SIZE (10),
    .G_DATA_SIZE    (16),
    .G_READ_LATENCY (L)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .avm   (bus),
    .err_o (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d, required end before limit)", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every data beat must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.avm_readdatavalid_o) begin
      if (sb.size() == 0) begin
        check("rvalid_without_request", bus.avm_readdatavalid_o, 1'b0);
      end else begin
        e = sb.pop_front();
        check("rd_data", bus.avm_readdata_o, e.d);
        check("rd_cycle", cyc, e.t);
      end
    end
  end

  // Hold the current request until accepted; t is the acceptance cycle.
  task automatic wait_accept(output int t);
    t = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!bus.avm_waitrequest_o) begin
        t = cyc;
        @(posedge clk);
        #1;
        break;
      end
      if (bus.avm_write_i && sb.size() == 0) idle_wait_cnt++;
    end
    if (t < 0) check("accept_timeout", bus.avm_waitrequest_o, 1'b0);
  endtask

  task automatic idle_bus();
    bus.avm_write_i      = 1'b0;
    bus.avm_read_i       = 1'b0;
    bus.avm_address_i    = '0;
    bus.avm_writedata_i  = '0;
    bus.avm_byteenable_i = '0;
    bus.avm_burstcount_i = '0;
  endtask

  task automatic write_single(input logic [31:0] a, input logic [15:0] d,
                              input logic [1:0] be, input logic [7:0] n, input bit also_read);
    int t;
    bus.avm_write_i      = 1'b1;
    bus.avm_read_i       = also_read;
    bus.avm_address_i    = a;
    bus.avm_writedata_i  = d;
    bus.avm_byteenable_i = be;
    bus.avm_burstcount_i = n;
    wait_accept(t);
    idle_bus();
  endtask

  // Burst write of wvec[0..n-1]; address/burstcount after beat 0 are junk.
  task automatic write_burst(input logic [31:0] a, input int n);
    int t;
    bus.avm_write_i      = 1'b1;
    bus.avm_byteenable_i = 2'b11;
    for (int k = 0; k < n; k++) begin
      bus.avm_address_i    = (k == 0) ? a : 32'h0000_0155;
      bus.avm_burstcount_i = (k == 0) ? 8'(n) : 8'hFF;
      bus.avm_writedata_i  = wvec[k];
      wait_accept(t);
    end
    idle_bus();
  endtask

  // Read burst; expects exp_vec[0..n_push-1]. Optionally checks waitrequest
  // high from T+1 through the last beat and low the cycle after.
  task automatic read_burst(input logic [31:0] a, input int n, input int n_push,
                            input bit chk_wait, output int t);
    bus.avm_read_i       = 1'b1;
    bus.avm_address_i    = a;
    bus.avm_burstcount_i = 8'(n);
    wait_accept(t);
    idle_bus();
    for (int k = 0; k < n_push; k++) sb.push_back('{d: exp_vec[k], t: t + L + k});
    if (chk_wait) begin
      for (int c = 1; c <= L + n; c++) begin
        @(negedge clk);
`ifndef RESPONDER_RANDOM_WAIT_EN
        check("rd_waitrequest", bus.avm_waitrequest_o, (c < L + n));
`else
        if (c < L + n) check("rd_waitrequest", bus.avm_waitrequest_o, 1'b1);
`endif
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t;
    idle_bus();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_waitrequest", bus.avm_waitrequest_o, 1'b0);
    check("rst_rvalid", bus.avm_readdatavalid_o, 1'b0);
    check("rst_readdata", bus.avm_readdata_o, 16'h0000);
    check("rst_err", err, 1'b0);
    @(posedge clk);
    #1;

    // Single write then single read with latency and waitrequest profile.
    write_single(32'h005, 16'hBEEF, 2'b11, 8'd1, 1'b0);
    exp_vec[0] = 16'hBEEF;
    read_burst(32'h005, 1, 1, 1'b1, t);

    // Burst of 4 wrapping across the top of memory.
    wvec[0] = 16'h1111; wvec[1] = 16'h2222; wvec[2] = 16'h3333; wvec[3] = 16'h4444;
    write_burst(32'h3FE, 4);
    exp_vec[0] = 16'h1111; exp_vec[1] = 16'h2222; exp_vec[2] = 16'h3333; exp_vec[3] = 16'h4444;
    read_burst(32'h3FE, 4, 4, 1'b1, t);
    exp_vec[0] = 16'h3333; exp_vec[1] = 16'h4444;
    read_burst(32'h000, 2, 2, 1'b0, t);

    // Byte enables: upper byte kept, lower byte replaced.
    write_single(32'h010, 16'hAAAA, 2'b11, 8'd1, 1'b0);
    write_single(32'h010, 16'h5555, 2'b01, 8'd1, 1'b0);
    exp_vec[0] = 16'hAA55;
    read_burst(32'h010, 1, 1, 1'b0, t);

    // burstcount 0 is a single beat: the next write lands at its own address.
    write_single(32'h030, 16'h0A0A, 2'b11, 8'd0, 1'b0);
    write_single(32'h040, 16'h0B0B, 2'b11, 8'd1, 1'b0);
    exp_vec[0] = 16'h0A0A;
    read_burst(32'h030, 1, 1, 1'b0, t);
    exp_vec[0] = 16'h0B0B;
    read_burst(32'h040, 1, 1, 1'b0, t);

    // Read and write together: write performed, read dropped, err sticky.
    @(negedge clk);
    check("err_before_collision", err, 1'b0);
    @(posedge clk);
    #1;
    write_single(32'h020, 16'h1234, 2'b11, 8'd1, 1'b1);
    @(negedge clk);
    check("err_set", err, 1'b1);
    @(posedge clk);
    #1;
    exp_vec[0] = 16'h1234;
    read_burst(32'h020, 1, 1, 1'b0, t);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("err_sticky", err, 1'b1);
    @(posedge clk);
    #1;

    // Reset after 3 of 8 read beats.
    for (int k = 0; k < 8; k++) wvec[k] = 16'hC000 + 16'(k);
    write_burst(32'h100, 8);
    for (int k = 0; k < 8; k++) exp_vec[k] = 16'hC000 + 16'(k);
    read_burst(32'h100, 8, 3, 1'b0, t);
    do @(negedge clk); while (cyc < t + L + 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_rvalid", bus.avm_readdatavalid_o, 1'b0);
    check("midrst_waitrequest", bus.avm_waitrequest_o, 1'b0);
    check("midrst_err_cleared", err, 1'b0);
    @(posedge clk);
    #1;
    read_burst(32'h100, 8, 8, 1'b0, t);

`ifdef RESPONDER_RANDOM_WAIT_EN
    // Random single writes then reads under random stalls.
    begin
      logic [15:0] rnd [256];
      idle_wait_cnt = 0;
      for (int i = 0; i < 256; i++) begin
        rnd[i] = 16'($urandom);
        write_single(32'h200 + 32'(i), rnd[i], 2'b11, 8'd1, 1'b0);
      end
      check("idle_wait_seen", (idle_wait_cnt != 0), 1'b1);
      for (int i = 0; i < 256; i++) begin
        exp_vec[0] = rnd[i];
        read_burst(32'h200 + 32'(i), 1, 1, 1'b0, t);
      end
    end
`endif

    // Drain outstanding beats.
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
